window_stream: RTL and testbench
================================

// Module: window_stream
// PURPOSE
//  Parametrised successor to the fixed 4x4-to-3x3 pixel window selector. Captures one BUF_DIM x BUF_DIM
//  pixel tile, then autonomously streams every WIN_DIM x WIN_DIM window at step STRIDE in raster order.
//  Sits between the tile buffer and the convolution engine; valid/ready on both sides.
// PARAMETERS
//  PIX_W    8  bits per pixel
//  BUF_DIM  4  tile edge length, in pixels
//  WIN_DIM  3  window edge length, in pixels (<= BUF_DIM; must be odd when PAD_WINDOW_EN is defined)
//  STRIDE   1  step between windows, in pixels (>= 1)
// PORTS
//  clk         in   1                    clock, rising edge
//  rst         in   1                    synchronous reset, active-high
//  in_valid    in   1                    in_tile is valid
//  in_ready    out  1                    block can accept a tile
//  in_tile     in   BUF_DIM^2*PIX_W      pixel(r,c) at bits [(r*BUF_DIM+c)*PIX_W +: PIX_W]
//  out_valid   out  1                    out_window is valid
//  out_ready   in   1                    consumer accepts out_window
//  out_window  out  WIN_DIM^2*PIX_W      window pixel(r,c), packed as in_tile with WIN_DIM in place of BUF_DIM
//  out_row     out  $clog2(NPOS)+1       window row index (0..NPOS-1)
//  out_col     out  $clog2(NPOS)+1       window column index (0..NPOS-1)
//  out_last    out  1                    current window is the last one for this tile
//  abort       in   1                    flush the current tile, return to IDLE
// BEHAVIOUR
//  - Window origin: P = 0 without padding. Window (i,j) takes pixel(r,c) = tile(i*STRIDE+r-P, j*STRIDE+c-P).
//  - NPOS = (BUF_DIM + 2P - WIN_DIM)/STRIDE + 1 (integer division). Windows per tile = NPOS^2.
//  - FSM states:
//    - IDLE: in_ready = 1, out_valid = 0.
//    - STREAM: in_ready = 0, out_valid = 1.
//  - IDLE -> STREAM on the in_valid && in_ready handshake:
//    - the tile is registered and (row, col) is set to (0,0);
//    - out_valid rises on the next cycle, so latency is 1 cycle.
//  - In STREAM, out_window, out_row, out_col and out_last stay stable while out_valid && !out_ready.
//    They are a combinational mux of the registered tile and registered row/col.
//  - Each out handshake advances the position:
//    - col increments by 1;
//    - when col == NPOS-1, col returns to 0 and row increments by 1.
//  - Handshake with out_last = 1 (row == col == NPOS-1): go to IDLE; in_ready = 1 on the next cycle.
//    No back-to-back overlap: the next tile is accepted no earlier than 1 cycle after the last window.
//  - out_last = out_valid && (row == NPOS-1) && (col == NPOS-1).
//  - abort (sync): next state is IDLE, row/col are cleared, out_valid = 0 on the next cycle.
//    - abort overrides a same-cycle in or out handshake; that tile or window is discarded.
//    - abort in IDLE has no effect, and in_tile is not captured that cycle.
//  - rst overrides abort and all handshakes.
//    - Reset state: IDLE, tile register = 0, row = col = 0, out_valid = 0, out_last = 0, out_window = 0.
//    - in_ready = 0 while rst is high; in_ready = 1 on the first cycle after rst is released.
//  - rst mid-STREAM drops the tile; no further windows are emitted.
//  - in_valid while in STREAM is ignored, since in_ready = 0 there.
// CONFIGURATION
//  PAD_WINDOW_EN defined:
//    - P = (WIN_DIM-1)/2 with zero padding: pixels outside the tile read as 0;
//    - NPOS = (BUF_DIM-1)/STRIDE + 1, so window (i,j) is centred on tile(i*STRIDE, j*STRIDE).
//  PAD_WINDOW_EN undefined:
//    - P = 0, no padding logic is built, and windows lie fully inside the tile.
// TESTING (defaults; tile(r,c) = r*4+c+1)
//  1. No pad; load tile; out_ready = 1 -> 4 windows in order (0,0),(0,1),(1,0),(1,1).
//     Centre pixels are 6, 7, 10, 11; out_last only on the 4th; in_ready = 1 the cycle after.
//  2. Backpressure: hold out_ready = 0 for 5 cycles at window (0,1).
//     -> out_window, out_row and out_col stay unchanged; no window is skipped or repeated.
//  3. abort asserted together with the 2nd window handshake.
//     -> out_valid = 0 next cycle, in_ready = 1; a reloaded tile restarts at (0,0).
//  4. rst pulse mid-STREAM -> out_valid = 0 and in_ready = 1 on the first cycle after release.
//     All outputs read 0 during reset.
//  5. PAD_WINDOW_EN -> 16 windows. Window (0,0) has row 0 and column 0 all zero, centre 1.
//     Window (3,3) has centre 16 and row 2 / column 2 all zero.
//  6. BUF_DIM = 6, WIN_DIM = 3, STRIDE = 2, no pad -> NPOS = 2.
//     Window (1,1) top-left pixel = tile(2,2) = 15.

Source files
------------

// File: rtl/window_stream.sv
// Captures one BUF_DIM x BUF_DIM tile and streams every WIN_DIM x WIN_DIM window at STRIDE
// in raster order. Optional zero padding around the tile is enabled by defining PAD_WINDOW_EN.
module window_stream #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned BUF_DIM = 4,
    parameter int unsigned WIN_DIM = 3,
    parameter int unsigned STRIDE  = 1,
`ifdef PAD_WINDOW_EN
    localparam int unsigned PAD    = (WIN_DIM - 1) / 2,
`else
    localparam int unsigned PAD    = 0,
`endif
    localparam int unsigned NPOS   = (BUF_DIM + 2 * PAD - WIN_DIM) / STRIDE + 1,
    localparam int unsigned POS_W  = $clog2(NPOS) + 1,
    localparam int unsigned TILE_W = BUF_DIM * BUF_DIM * PIX_W,
    localparam int unsigned WIN_W  = WIN_DIM * WIN_DIM * PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TILE_W-1:0] in_tile,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIN_W-1:0]  out_window,
    output logic [POS_W-1:0]  out_row,
    output logic [POS_W-1:0]  out_col,
    output logic              out_last,
    input  logic              abort
);

    localparam int unsigned BI_W = (BUF_DIM > 1) ? $clog2(BUF_DIM) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NPOS - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e            state_q, state_d;
    logic [TILE_W-1:0] tile_q;
    logic [POS_W-1:0]  row_q, row_d;
    logic [POS_W-1:0]  col_q, col_d;
    logic              tile_load;
    logic              last_pos;

    logic [PIX_W-1:0]  pix [BUF_DIM][BUF_DIM];
    logic [WIN_W-1:0]  win;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tile_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            if (tile_load) begin
                tile_q <= in_tile;
            end
        end
    end

    assign last_pos = (row_q == LAST_POS) && (col_q == LAST_POS);

    // Next-state logic; abort wins over any handshake in the same cycle
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tile_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !abort) begin
                    state_d   = StStream;
                    row_d     = '0;
                    col_d     = '0;
                    tile_load = 1'b1;
                end
            end
            StStream: begin
                if (abort) begin
                    state_d = StIdle;
                    row_d   = '0;
                    col_d   = '0;
                end else if (out_ready) begin
                    if (last_pos) begin
                        state_d = StIdle;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == LAST_POS) begin
                        col_d = '0;
                        row_d = row_q + POS_W'(1);
                    end else begin
                        col_d = col_q + POS_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        for (int r = 0; r < int'(BUF_DIM); r++) begin
            for (int c = 0; c < int'(BUF_DIM); c++) begin
                pix[r][c] = tile_q[(r * BUF_DIM + c) * PIX_W +: PIX_W];
            end
        end
    end

    // Window mux over the registered tile; padded positions outside the tile read as zero
    always_comb begin
        win = '0;
        for (int r = 0; r < int'(WIN_DIM); r++) begin
            for (int c = 0; c < int'(WIN_DIM); c++) begin
                int tr;
                int tc;
                tr = int'(row_q) * int'(STRIDE) + r - int'(PAD);
                tc = int'(col_q) * int'(STRIDE) + c - int'(PAD);
`ifdef PAD_WINDOW_EN
                if (tr >= 0 && tr < int'(BUF_DIM) && tc >= 0 && tc < int'(BUF_DIM)) begin
                    win[(r * WIN_DIM + c) * PIX_W +: PIX_W] = pix[BI_W'(tr)][BI_W'(tc)];
                end
`else
                win[(r * WIN_DIM + c) * PIX_W +: PIX_W] = pix[BI_W'(tr)][BI_W'(tc)];
`endif
            end
        end
    end

    // Outputs; everything reads zero while rst is held, even before the registers clear
    always_comb begin
        in_ready   = !rst && (state_q == StIdle);
        out_valid  = !rst && (state_q == StStream);
        out_last   = out_valid && last_pos;
        out_window = out_valid ? win : '0;
        out_row    = out_valid ? row_q : '0;
        out_col    = out_valid ? col_q : '0;
    end

endmodule

// File: tb/tb_window_stream.sv
// Randomized bench for window_stream: a queue of expected windows per accepted tile is the model.
// A second instance (BUF_DIM 6, STRIDE 2) covers the strided configuration.
module tb_window_stream;

    localparam int PW = 8;
    localparam int BD = 4;
    localparam int WD = 3;
    localparam int ST = 1;
    localparam int BD2 = 6;
    localparam int ST2 = 2;
`ifdef PAD_WINDOW_EN
    localparam int PT = (WD - 1) / 2;
`else
    localparam int PT = 0;
`endif
    localparam int NP = (BD + 2 * PT - WD) / ST + 1;
    localparam int NP2 = (BD2 + 2 * PT - WD) / ST2 + 1;
    localparam int POS_W = $clog2(NP) + 1;
    localparam int POS_W2 = $clog2(NP2) + 1;
    localparam int TILE_W = BD * BD * PW;
    localparam int TILE_W2 = BD2 * BD2 * PW;
    localparam int WIN_W = WD * WD * PW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last, abort = 1'b0;
    logic [TILE_W-1:0] in_tile = '0;
    logic [WIN_W-1:0] out_window;
    logic [POS_W-1:0] out_row, out_col;

    logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_last;
    logic [TILE_W2-1:0] b_in_tile = '0;
    logic [WIN_W-1:0] b_out_window;
    logic [POS_W2-1:0] b_out_row, b_out_col;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        int row;
        int col;
        logic [WIN_W-1:0] win;
    } win_t;
    win_t expq[$];

    always #5 clk = ~clk;

    window_stream #(.PIX_W(PW), .BUF_DIM(BD), .WIN_DIM(WD), .STRIDE(ST)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tile(in_tile),
        .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .abort(abort)
    );

    window_stream #(.PIX_W(PW), .BUF_DIM(BD2), .WIN_DIM(WD), .STRIDE(ST2)) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_tile(b_in_tile),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_window(b_out_window),
        .out_row(b_out_row), .out_col(b_out_col), .out_last(b_out_last), .abort(1'b0)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Window (i,j) of a BD x BD tile: pixel(r,c) = tile(i*ST+r-PT, j*ST+c-PT), zero outside
    function automatic logic [WIN_W-1:0] win_of(input logic [TILE_W-1:0] t, input int i,
                                                 input int j);
        logic [WIN_W-1:0] w;
        int tr, tc;
        w = '0;
        for (int r = 0; r < WD; r++) begin
            for (int c = 0; c < WD; c++) begin
                tr = i * ST + r - PT;
                tc = j * ST + c - PT;
                if (tr >= 0 && tr < BD && tc >= 0 && tc < BD)
                    w[(r * WD + c) * PW +: PW] = t[(tr * BD + tc) * PW +: PW];
            end
        end
        return w;
    endfunction

    function automatic logic [TILE_W-1:0] ramp_tile();
        logic [TILE_W-1:0] t;
        for (int k = 0; k < BD * BD; k++) t[k * PW +: PW] = PW'(k + 1);
        return t;
    endfunction

    function automatic logic [TILE_W-1:0] rand_tile();
        logic [TILE_W-1:0] t;
        for (int k = 0; k < BD * BD; k++) t[k * PW +: PW] = PW'($urandom);
        return t;
    endfunction

    task automatic load_model(input logic [TILE_W-1:0] t);
        win_t e;
        for (int i = 0; i < NP; i++) begin
            for (int j = 0; j < NP; j++) begin
                e.row = i;
                e.col = j;
                e.win = win_of(t, i, j);
                expq.push_back(e);
            end
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance the model with the sampled handshakes
    task automatic step(input logic iv, input logic [TILE_W-1:0] t, input logic ordy,
                        input logic ab);
        bit busy;
        in_valid = iv;
        in_tile = t;
        out_ready = ordy;
        abort = ab;
        @(negedge clk);
        busy = (expq.size() > 0);
        check("in_ready", in_ready, !busy);
        check("out_valid", out_valid, busy);
        if (busy) begin
            check("out_row", out_row, expq[0].row);
            check("out_col", out_col, expq[0].col);
            check("out_last", out_last, expq.size() == 1);
            check("out_window", out_window, expq[0].win);
        end else begin
            check("out_last_idle", out_last, 1'b0);
        end
        @(posedge clk);
        #1;
        if (ab) expq.delete();
        else if (!busy && iv) load_model(t);
        else if (busy && ordy) void'(expq.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_last", out_last, 1'b0);
            check("rst_out_window", out_window, '0);
            check("rst_out_row", out_row, '0);
            check("rst_out_col", out_col, '0);
            check("rst_b_out_valid", b_out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        expq.delete();
    endtask

    initial begin
        logic [TILE_W-1:0] t1;
        logic [TILE_W2-1:0] tb2;
        int cent[4];
        int cnt;
        int tr, tc, v;
        logic [WIN_W-1:0] bw;

        cent = '{6, 7, 10, 11};
        t1 = ramp_tile();
        @(posedge clk);
        #1;
        do_reset(2);

        // Ramp tile, out_ready held high
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, t1, 1'b1, 1'b0);
        for (int k = 0; k < NP * NP; k++) begin
`ifdef PAD_WINDOW_EN
            if (k == 0) begin
                check("pad00_centre", out_window[4 * PW +: PW], 1);
                check("pad00_row0", out_window[0 +: 3 * PW], '0);
                check("pad00_col0", {out_window[3 * PW +: PW], out_window[6 * PW +: PW]}, '0);
            end
            if (k == NP * NP - 1) begin
                check("pad33_centre", out_window[4 * PW +: PW], 16);
                check("pad33_row2", out_window[6 * PW +: 3 * PW], '0);
                check("pad33_col2", {out_window[2 * PW +: PW], out_window[5 * PW +: PW]}, '0);
            end
`else
            check("centre", out_window[4 * PW +: PW], cent[k]);
`endif
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure at window (0,1)
        step(1'b1, t1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < NP * NP; k++) step(1'b0, '0, 1'b1, 1'b0);

        // Abort on the second window handshake, then reload
        step(1'b1, t1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_tile(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Abort in IDLE must not capture the offered tile
        for (int k = 0; k < NP * NP; k++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, rand_tile(), 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Reset pulse mid-stream
        step(1'b1, rand_tile(), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        do_reset(2);
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(1, 0) == 1, rand_tile(), $urandom_range(9, 0) < 7,
                 $urandom_range(24, 0) == 0);
        end
        abort = 1'b0;
        in_valid = 1'b0;

        // Strided instance
        for (int k = 0; k < BD2 * BD2; k++) tb2[k * PW +: PW] = PW'(k + 1);
        b_in_tile = tb2;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;
        cnt = 0;
        for (int cyc = 0; cyc < 40 && cnt < NP2 * NP2; cyc++) begin
            @(negedge clk);
            if (b_out_valid) begin
                bw = '0;
                for (int r = 0; r < WD; r++) begin
                    for (int c = 0; c < WD; c++) begin
                        tr = (cnt / NP2) * ST2 + r - PT;
                        tc = (cnt % NP2) * ST2 + c - PT;
                        v = (tr >= 0 && tr < BD2 && tc >= 0 && tc < BD2) ? tr * BD2 + tc + 1 : 0;
                        bw[(r * WD + c) * PW +: PW] = PW'(v);
                    end
                end
                check("s2_row", b_out_row, cnt / NP2);
                check("s2_col", b_out_col, cnt % NP2);
                check("s2_last", b_out_last, cnt == NP2 * NP2 - 1);
                check("s2_window", b_out_window, bw);
`ifndef PAD_WINDOW_EN
                if (cnt == 3) check("s2_w11_topleft", b_out_window[0 +: PW], 15);
`endif
                cnt++;
            end
            @(posedge clk);
            #1;
        end
        check("s2_count", cnt, NP2 * NP2);
        @(negedge clk);
        check("s2_in_ready_after", b_in_ready, 1'b1);
        check("s2_out_valid_after", b_out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
